// File: rtl/spi_cmd_regfile.sv
// Purpose : SPI command parser + NUM_REGS x 8-bit register bank ({rw,addr} command, auto-increment burst).
// Latency : rxd_flag -> register write / wr_strobe / txd_data update = 1 clk.
// Backpr. : none; one byte per rxd_flag, bytes are consumed unconditionally while CS_N is low.
//
// Ports:
//   i_clk, i_rst_n          system clock, async active-low reset
//   i_cs_n                  raw SPI chip select (asynchronous, synchronised here)
//   i_rxd_data, i_rxd_flag  received byte and its 1-clk strobe
//   o_txd_data              byte the slave transmits in the next byte slot
//   o_regs_out              flattened registers, reg k at [8k+7:8k]
//   o_wr_strobe, o_wr_addr  1-clk write pulse and address of the last write
//   o_frame_err             sticky: command byte with no data byte before frame end
module spi_cmd_regfile #(
    parameter int         NUM_REGS  = 8,
    parameter logic [7:0] RD_EMPTY  = 8'h00,
    parameter logic [7:0] IDLE_BYTE = 8'hA5
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_cs_n,
    input  logic [7:0]            i_rxd_data,
    input  logic                  i_rxd_flag,
    output logic [7:0]            o_txd_data,
    output logic [NUM_REGS*8-1:0] o_regs_out,
    output logic                  o_wr_strobe,
    output logic [6:0]            o_wr_addr,
    output logic                  o_frame_err
);

    typedef enum logic {ST_CMD, ST_DATA} state_t;

    localparam logic [7:0] NREGS_B = 8'(NUM_REGS);

    state_t     r_state, w_state_nxt;
    logic       r_cs_meta, r_cs_s, r_cs_prev;
    logic [6:0] r_addr, w_addr_nxt;
    logic       r_mode, w_mode_nxt;   // 1 = write burst, 0 = read burst
    logic       r_got, w_got_nxt;     // at least one data byte seen in this frame
    logic [7:0] r_txd, w_txd_nxt;
    logic       r_wr_strobe;
    logic [6:0] r_wr_addr;
    logic       r_frame_err;
    logic       w_we, w_err_set, w_cs_rise, w_accept;
    logic [7:0] r_regs   [NUM_REGS];
    logic [7:0] w_rd_tbl [128];

    // Full 7-bit read map: unmapped addresses return RD_EMPTY, so the read
    // path can index with the raw address and never go out of range.
    for (genvar k = 0; k < 128; k++) begin : g_tbl
        if (k < NUM_REGS) begin : g_map
            assign w_rd_tbl[k] = r_regs[k];
        end else begin : g_unm
            assign w_rd_tbl[k] = RD_EMPTY;
        end
    end

    for (genvar k = 0; k < NUM_REGS; k++) begin : g_out
        assign o_regs_out[8*k +: 8] = r_regs[k];
    end

    assign o_txd_data  = r_txd;
    assign o_wr_strobe = r_wr_strobe;
    assign o_wr_addr   = r_wr_addr;
    assign o_frame_err = r_frame_err;

    // A byte landing in the very clk where the synchronised CS_N first reads
    // high still belongs to the closing frame and is processed.
    assign w_cs_rise = r_cs_s & ~r_cs_prev;
    assign w_accept  = i_rxd_flag & (~r_cs_s | w_cs_rise);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= ST_CMD;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_addr_nxt  = r_addr;
        w_mode_nxt  = r_mode;
        w_got_nxt   = r_got;
        w_txd_nxt   = r_txd;
        w_we        = 1'b0;
        w_err_set   = 1'b0;
        if (w_accept) begin
            case (r_state)
                ST_CMD: begin
                    w_addr_nxt  = i_rxd_data[6:0];
                    w_mode_nxt  = i_rxd_data[7];
                    w_got_nxt   = 1'b0;
                    w_txd_nxt   = i_rxd_data[7] ? IDLE_BYTE : w_rd_tbl[i_rxd_data[6:0]];
                    w_state_nxt = ST_DATA;
                end
                default: begin
                    w_we       = r_mode && ({1'b0, r_addr} < NREGS_B);
                    w_txd_nxt  = r_mode ? IDLE_BYTE : w_rd_tbl[r_addr + 7'd1];
                    w_addr_nxt = r_addr + 7'd1;
                    w_got_nxt  = 1'b1;
                end
            endcase
        end
        // Deselected: any byte above has already been applied, now close the frame.
        if (r_cs_s) begin
            w_err_set   = (w_state_nxt == ST_DATA) && !w_got_nxt;
            w_state_nxt = ST_CMD;
            w_txd_nxt   = IDLE_BYTE;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cs_meta   <= 1'b1;
            r_cs_s      <= 1'b1;
            r_cs_prev   <= 1'b1;
            r_addr      <= 7'd0;
            r_mode      <= 1'b0;
            r_got       <= 1'b0;
            r_txd       <= IDLE_BYTE;
            r_wr_strobe <= 1'b0;
            r_wr_addr   <= 7'd0;
            r_frame_err <= 1'b0;
            for (int k = 0; k < NUM_REGS; k++) begin
                r_regs[k] <= 8'h00;
            end
        end else begin
            r_cs_meta   <= i_cs_n;
            r_cs_s      <= r_cs_meta;
            r_cs_prev   <= r_cs_s;
            r_addr      <= w_addr_nxt;
            r_mode      <= w_mode_nxt;
            r_got       <= w_got_nxt;
            r_txd       <= w_txd_nxt;
            r_wr_strobe <= w_we;
            if (w_we) begin
                r_wr_addr <= r_addr;
            end
            if (w_err_set) begin
                r_frame_err <= 1'b1;
            end
            for (int k = 0; k < NUM_REGS; k++) begin
                if (w_we && (r_addr == 7'(k))) begin
                    r_regs[k] <= i_rxd_data;
                end
            end
        end
    end

endmodule
